// File: rtl/csr_spmv_engine_if.sv
// Stream bundle for csr_spmv_engine: matrix-entry load, vector load and row-result output.
// The engine connects to the slave modport. The producer/consumer side connects to the master modport.
interface csr_spmv_engine_if #(
  parameter int unsigned N_ROWS = 4,
  parameter int unsigned N_COLS = 4,
  parameter int unsigned VW     = 8,
  parameter int unsigned XW     = 8,
  parameter int unsigned AW     = 16
);
  localparam int unsigned RW = $clog2(N_ROWS);
  localparam int unsigned CW = $clog2(N_COLS);

  logic          ld_valid;
  logic          ld_ready;
  logic          ld_last;
  logic [RW-1:0] ld_row;
  logic [CW-1:0] ld_col;
  logic [VW-1:0] ld_val;

  logic          vec_valid;
  logic          vec_ready;
  logic [XW-1:0] vec_data;

  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic          out_last;

  modport master (
    output ld_valid, ld_last, ld_row, ld_col, ld_val,
    input  ld_ready,
    output vec_valid, vec_data,
    input  vec_ready,
    input  out_valid, out_data, out_row, out_last,
    output out_ready
  );

  modport slave (
    input  ld_valid, ld_last, ld_row, ld_col, ld_val,
    output ld_ready,
    input  vec_valid, vec_data,
    output vec_ready,
    output out_valid, out_data, out_row, out_last,
    input  out_ready
  );
endinterface

// File: rtl/csr_spmv_engine.sv
// Sparse (row-sorted CSR/COO stream) matrix times dense vector engine.
// It supports spike and integer vector modes, matrix reuse across jobs, saturating accumulators and sticky error flags.
module csr_spmv_engine #(
  parameter int unsigned N_ROWS  = 4,
  parameter int unsigned N_COLS  = 4,
  parameter int unsigned NNZ_MAX = 16,
  parameter int unsigned VW      = 8,
  parameter int unsigned XW      = 8,
  parameter int unsigned AW      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              reuse_mat,
  input  logic              mode,
  csr_spmv_engine_if.slave  bus,
  output logic              busy,
  output logic [2:0]        err,
  output logic              sat
);
  localparam int unsigned RW = $clog2(N_ROWS);
  localparam int unsigned CW = $clog2(N_COLS);
  localparam int unsigned NW = $clog2(NNZ_MAX + 1);
  localparam int unsigned IW = $clog2(NNZ_MAX);
  localparam int unsigned PW = VW + XW;
  localparam int unsigned SW = ((AW > PW) ? AW : PW) + 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_MAT = 3'd1,
    S_LOAD_VEC = 3'd2,
    S_COMPUTE  = 3'd3,
    S_DRAIN    = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [NW-1:0] nnz_q, nnz_d;
  logic [NW-1:0] k_q, k_d;
  logic          mat_valid_q, mat_valid_d;
  logic [RW-1:0] prev_row_q, prev_row_d;
  logic [2:0]    err_q, err_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] vidx_q, vidx_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] acc_q [N_ROWS];
  logic [AW-1:0] acc_d [N_ROWS];
  logic          rsat_q [N_ROWS];
  logic          rsat_d [N_ROWS];

  logic          ld_ready_q, vec_ready_q, out_valid_q, out_last_q, busy_q, sat_q;
  logic [AW-1:0] out_data_q;
  logic [RW-1:0] out_row_q;

  // Entry and vector storage; never reset
  logic [RW-1:0] row_mem [NNZ_MAX];
  logic [CW-1:0] col_mem [NNZ_MAX];
  logic [VW-1:0] val_mem [NNZ_MAX];
  logic [XW-1:0] x_mem   [N_COLS];

  logic          ld_hs, vec_hs, out_hs;
  logic          ent_we, x_we, out_load;
  logic          drop_full, drop_order, drop_range;
  logic [RW-1:0] e_row;
  logic [CW-1:0] e_col;
  logic [VW-1:0] e_val;
  logic [XW-1:0] x_op;
  logic [PW-1:0] prod;
  logic [SW-1:0] sum;
  logic          last_k;

  assign ld_hs  = bus.ld_valid && ld_ready_q;
  assign vec_hs = bus.vec_valid && vec_ready_q;
  assign out_hs = out_valid_q && bus.out_ready;

  // Multiply-accumulate datapath for the entry addressed by k
  assign e_row  = row_mem[k_q[IW-1:0]];
  assign e_col  = col_mem[k_q[IW-1:0]];
  assign e_val  = val_mem[k_q[IW-1:0]];
  assign x_op   = mode_q ? x_mem[e_col] : XW'(x_mem[e_col][0]);
  assign prod   = PW'(e_val) * PW'(x_op);
  assign sum    = SW'(acc_q[e_row]) + SW'(prod);
  assign last_k = (k_q + NW'(1)) >= nnz_q;

  always_comb begin
    state_d     = state_q;
    nnz_d       = nnz_q;
    k_d         = k_q;
    mat_valid_d = mat_valid_q;
    prev_row_d  = prev_row_q;
    err_d       = err_q;
    mode_d      = mode_q;
    vidx_d      = vidx_q;
    row_d       = row_q;
    acc_d       = acc_q;
    rsat_d      = rsat_q;
    ent_we      = 1'b0;
    x_we        = 1'b0;
    out_load    = 1'b0;
    drop_full   = 1'b0;
    drop_order  = 1'b0;
    drop_range  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d  = '0;
          mode_d = mode;
          vidx_d = '0;
          if (reuse_mat && mat_valid_q) begin
            state_d = S_LOAD_VEC;
          end else begin
            state_d     = S_LOAD_MAT;
            nnz_d       = '0;
            prev_row_d  = '0;
            mat_valid_d = 1'b0;
          end
        end
      end
      S_LOAD_MAT: begin
        if (ld_hs) begin
          drop_full  = (nnz_q == NW'(NNZ_MAX));
          drop_order = (bus.ld_row < prev_row_q);
          drop_range = (32'(bus.ld_row) >= N_ROWS) || (32'(bus.ld_col) >= N_COLS);
          err_d      = err_q | {drop_range, drop_order, drop_full};
          if (!(drop_full || drop_order || drop_range)) begin
            ent_we     = 1'b1;
            nnz_d      = nnz_q + NW'(1);
            prev_row_d = bus.ld_row;
          end
          // A last beat closes the matrix even if the beat itself was dropped
          if (bus.ld_last) begin
            mat_valid_d = 1'b1;
            state_d     = S_LOAD_VEC;
          end
        end
      end
      S_LOAD_VEC: begin
        if (vec_hs) begin
          x_we   = 1'b1;
          vidx_d = vidx_q + CW'(1);
          if (vidx_q == CW'(N_COLS - 1)) begin
            state_d = S_COMPUTE;
            k_d     = '0;
            for (int r = 0; r < int'(N_ROWS); r++) begin
              acc_d[r]  = '0;
              rsat_d[r] = 1'b0;
            end
          end
        end
      end
      S_COMPUTE: begin
        if (nnz_q != '0) begin
          if (sum > SW'({AW{1'b1}})) begin
            acc_d[e_row]  = '1;
            rsat_d[e_row] = 1'b1;
          end else begin
            acc_d[e_row] = AW'(sum);
          end
        end
        k_d = k_q + NW'(1);
        if (last_k) begin
          state_d  = S_DRAIN;
          row_d    = '0;
          out_load = 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_hs) begin
          if (row_q == RW'(N_ROWS - 1)) begin
            state_d = S_IDLE;
          end else begin
            row_d    = row_q + RW'(1);
            out_load = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rst_n is an active-high synchronous reset despite its name
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      nnz_q       <= '0;
      k_q         <= '0;
      mat_valid_q <= 1'b0;
      prev_row_q  <= '0;
      err_q       <= '0;
      mode_q      <= 1'b0;
      vidx_q      <= '0;
      row_q       <= '0;
      for (int r = 0; r < int'(N_ROWS); r++) begin
        acc_q[r]  <= '0;
        rsat_q[r] <= 1'b0;
      end
      ld_ready_q  <= 1'b0;
      vec_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      nnz_q       <= nnz_d;
      k_q         <= k_d;
      mat_valid_q <= mat_valid_d;
      prev_row_q  <= prev_row_d;
      err_q       <= err_d;
      mode_q      <= mode_d;
      vidx_q      <= vidx_d;
      row_q       <= row_d;
      acc_q       <= acc_d;
      rsat_q      <= rsat_d;
      ld_ready_q  <= (state_d == S_LOAD_MAT);
      vec_ready_q <= (state_d == S_LOAD_VEC);
      out_valid_q <= (state_d == S_DRAIN);
      busy_q      <= (state_d != S_IDLE);
      if (out_load) begin
        out_data_q <= acc_d[row_d];
        out_row_q  <= row_d;
        out_last_q <= (row_d == RW'(N_ROWS - 1));
        sat_q      <= rsat_d[row_d];
      end else if (state_d != S_DRAIN) begin
        out_data_q <= '0;
        out_row_q  <= '0;
        out_last_q <= 1'b0;
        sat_q      <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ent_we) begin
      row_mem[nnz_q[IW-1:0]] <= bus.ld_row;
      col_mem[nnz_q[IW-1:0]] <= bus.ld_col;
      val_mem[nnz_q[IW-1:0]] <= bus.ld_val;
    end
    if (x_we) begin
      x_mem[vidx_q] <= bus.vec_data;
    end
  end

  assign bus.ld_ready  = ld_ready_q;
  assign bus.vec_ready = vec_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = out_row_q;
  assign bus.out_last  = out_last_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign sat           = sat_q;
endmodule
